// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the carry-pipelined adder.
// Used by adder_pipe and adder_pipe_stage (optional macro ADDER_PIPE_OVF_EN lives in those files).
package adder_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultStages = 4;

  // Bits handled by each pipeline stage.
  function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit slicing_ok(int unsigned width, int unsigned stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One slice of the carry-pipelined adder: adds its SliceWidth bits and registers the result.
// With ADDER_PIPE_OVF_EN defined it also registers the signed-overflow flag.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int unsigned Width      = DefaultWidth,
  parameter int unsigned SliceWidth = 4,
  parameter int unsigned SliceIdx   = 0,
  parameter bit          IsLast     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] psum_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [Width-1:0] a_o,
  output logic [Width-1:0] b_o,
  output logic [Width-1:0] psum_o,
  output logic             carry_o
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned Lsb = SliceIdx * SliceWidth;

  logic                  en;
  logic                  valid_d, valid_q;
  logic                  carry_d, carry_q;
  logic [SliceWidth:0]   slice_add;
  logic [Width-1:0]      psum_new, psum_d, psum_q;
  logic [Width-1:0]      a_d, a_q, b_d, b_q;

  // Data only moves when a valid item advances, so bubbles never disturb held values.
  always_comb begin
    en        = adv && valid_i;
    slice_add = {1'b0, a_i[Lsb +: SliceWidth]} + {1'b0, b_i[Lsb +: SliceWidth]}
              + {{SliceWidth{1'b0}}, carry_i};
    psum_new  = psum_i;
    psum_new[Lsb +: SliceWidth] = slice_add[SliceWidth-1:0];
    valid_d   = adv ? valid_i : valid_q;
    psum_d    = en ? psum_new : psum_q;
    carry_d   = en ? slice_add[SliceWidth] : carry_q;
    a_d       = en ? a_i : a_q;
    b_d       = en ? b_i : b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Operand bits already consumed are dead downstream and get trimmed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  if (IsLast) begin : g_out_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum_q  <= '0;
        carry_q <= 1'b0;
      end else begin
        psum_q  <= psum_d;
        carry_q <= carry_d;
      end
    end
  end else begin : g_mid_regs
    always_ff @(posedge clk) begin
      psum_q  <= psum_d;
      carry_q <= carry_d;
    end
  end

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_d, ovf_q;

  // Only meaningful in the last stage, whose slice holds the MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (en) begin
      ovf_d = (a_i[Width-1] == b_i[Width-1]) && (psum_new[Width-1] != a_i[Width-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign psum_o  = psum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe.sv
// WIDTH-bit adder split into STAGES registered slices with valid/ready flow control.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output ovf.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic             valid_p [STAGES+1];
  logic             carry_p [STAGES+1];
  logic [WIDTH-1:0] a_p     [STAGES+1];
  logic [WIDTH-1:0] b_p     [STAGES+1];
  logic [WIDTH-1:0] psum_p  [STAGES+1];

  // Whole pipe moves in lockstep; it only stalls when a finished result is not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign valid_p[0] = in_valid;
  assign carry_p[0] = cin;
  assign a_p[0]     = a;
  assign b_p[0]     = b;
  assign psum_p[0]  = '0;

`ifdef ADDER_PIPE_OVF_EN
  logic [STAGES-1:0] ovf_st;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .Width     (WIDTH),
      .SliceWidth(SW),
      .SliceIdx  (k),
      .IsLast    (k == STAGES - 1)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .valid_i(valid_p[k]),
      .a_i    (a_p[k]),
      .b_i    (b_p[k]),
      .psum_i (psum_p[k]),
      .carry_i(carry_p[k]),
      .valid_o(valid_p[k+1]),
      .a_o    (a_p[k+1]),
      .b_o    (b_p[k+1]),
      .psum_o (psum_p[k+1]),
      .carry_o(carry_p[k+1])
`ifdef ADDER_PIPE_OVF_EN
      ,
      .ovf_o  (ovf_st[k])
`endif
    );
  end

  assign out_valid = valid_p[STAGES];
  assign sum       = psum_p[STAGES];
  assign cout      = carry_p[STAGES];

`ifdef ADDER_PIPE_OVF_EN
  assign ovf = ovf_st[STAGES-1];
  logic unused_ovf;
  assign unused_ovf = ^ovf_st;
`endif

  logic unused_tail;
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a 4-stage and a 1-stage instance share the same stimulus.
// Define ADDER_PIPE_OVF_EN to also exercise the ovf output.
module tb_adder_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        cin       = 1'b0;

  logic        in_ready, out_valid, cout;
  logic [15:0] sum;
  logic        in_ready1, out_valid1, cout1;
  logic [15:0] sum1;
`ifdef ADDER_PIPE_OVF_EN
  logic        ovf, ovf1;
`endif

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  adder_pipe #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .sum      (sum1),
    .cout     (cout1)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .ovf      (ovf1)
`endif
  );

  function automatic exp_t model(logic [15:0] x, logic [15:0] y, logic c);
    logic [16:0] r;
    exp_t        e;
    r      = {1'b0, x} + {1'b0, y} + {16'h0000, c};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (x[15] == y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  function automatic logic [15:0] item_a(int i);
    return 16'h1111 * 16'(i + 1);
  endfunction

  function automatic logic [15:0] item_b(int i);
    return 16'h0F0F + 16'(i);
  endfunction

  // Scoreboard: push on accepted input, pop and compare on each output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL sb4_extra: got sum=%h cout=%b, required no output", sum, cout);
        end else begin
          e4 = q4.pop_front();
          if (sum !== e4.sum || cout !== e4.cout) begin
            n_fail++;
            $display("FAIL sb4_data: got sum=%h cout=%b, required sum=%h cout=%b",
                     sum, cout, e4.sum, e4.cout);
          end
`ifdef ADDER_PIPE_OVF_EN
          if (ovf !== e4.ovf) begin
            n_fail++;
            $display("FAIL sb4_ovf: got ovf=%b, required ovf=%b", ovf, e4.ovf);
          end
`endif
        end
      end
      if (in_valid && in_ready) q4.push_back(model(a, b, cin));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid1 && out_ready) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_extra: got sum=%h cout=%b, required no output", sum1, cout1);
        end else begin
          e1 = q1.pop_front();
          if (sum1 !== e1.sum || cout1 !== e1.cout) begin
            n_fail++;
            $display("FAIL sb1_data: got sum=%h cout=%b, required sum=%h cout=%b",
                     sum1, cout1, e1.sum, e1.cout);
          end
`ifdef ADDER_PIPE_OVF_EN
          if (ovf1 !== e1.ovf) begin
            n_fail++;
            $display("FAIL sb1_ovf: got ovf=%b, required ovf=%b", ovf1, e1.ovf);
          end
`endif
        end
      end
      if (in_valid && in_ready1) q1.push_back(model(a, b, cin));
    end
  end

  task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic c);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out4(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b sum=%h cout=%b ir=%b, required 0 0000 0 1",
               out_valid, sum, cout, in_ready);
    end
`ifdef ADDER_PIPE_OVF_EN
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: got ir=%b ov=%b ir1=%b, required 1 0 1",
               in_ready, out_valid, in_ready1);
    end
  endtask

  task automatic test_basic;
    int cyc;
    send_one(16'hFFFF, 16'h0001, 1'b0);
    n_tests++;
    if (out_valid1 !== 1'b1 || sum1 !== 16'h0000 || cout1 !== 1'b1) begin
      n_fail++;
      $display("FAIL stages1_wrap: got ov=%b sum=%h cout=%b, required 1 0000 1",
               out_valid1, sum1, cout1);
    end
    wait_out4(cyc);
    n_tests++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL latency_wrap: got %0d cycles, required 4", cyc);
    end
    n_tests++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wrap: got sum=%h cout=%b, required 0000 1", sum, cout);
    end
    send_one(16'h1234, 16'h4321, 1'b1);
    wait_out4(cyc);
    n_tests++;
    if (cyc != 4 || sum !== 16'h5556 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_cin: got cyc=%0d sum=%h cout=%b, required 4 5556 0", cyc, sum, cout);
    end
  endtask

  task automatic test_ripple;
    int cyc;
    send_one(16'h0FFF, 16'h0001, 1'b0);
    n_tests++;
    if (out_valid1 !== 1'b1 || sum1 !== 16'h1000 || cout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL stages1_ripple: got ov=%b sum=%h cout=%b, required 1 1000 0",
               out_valid1, sum1, cout1);
    end
    wait_out4(cyc);
    n_tests++;
    if (cyc != 4 || sum !== 16'h1000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple: got cyc=%0d sum=%h cout=%b, required 4 1000 0", cyc, sum, cout);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int last  = -1;
    int cnt   = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        a        = 16'(c);
        b        = 16'h00FF * 16'(c);
        cin      = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (cnt != 8 || (last - first + 1) != 8 || first != 4) begin
      n_fail++;
      $display("FAIL stream: got cnt=%0d first=%0d last=%0d, required 8 4 11", cnt, first, last);
    end
  endtask

  task automatic test_backpressure;
    int   idx = 0;
    exp_t f;
    f         = model(item_a(0), item_b(0), 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a = item_a(idx); b = item_b(idx); cin = idx[0]; in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) break;
      idx++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (idx != 4) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d accepted, required 4", idx);
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== f.sum || cout !== f.cout) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ir=%b ov=%b sum=%h cout=%b, required 0 1 %h %b",
                 k, in_ready, out_valid, sum, cout, f.sum, f.cout);
      end
      @(posedge clk);
      #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 6; c++) begin
      a = item_a(idx); b = item_b(idx); cin = idx[0]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && (q4.size() > 0 || q1.size() > 0); c++) @(posedge clk);
    #1;
    n_tests++;
    if (idx != 6 || q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got idx=%0d pending4=%0d pending1=%0d, required 6 0 0",
               idx, q4.size(), q1.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int stale = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = 16'h0100 * 16'(c + 1); b = 16'h0003; cin = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got ov=%b, required 1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got ov=%b sum=%h cout=%b ov1=%b, required 0 0000 0 0",
               out_valid, sum, cout, out_valid1);
    end
    q4.delete();
    q1.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || out_valid1) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL rst_stale: got %0d valid cycles, required 0", stale);
    end
    send_one(16'h0001, 16'h0001, 1'b0);
    wait_out4(cyc);
    n_tests++;
    if (cyc != 4 || sum !== 16'h0002 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got cyc=%0d sum=%h cout=%b, required 4 0002 0", cyc, sum, cout);
    end
  endtask

`ifdef ADDER_PIPE_OVF_EN
  task automatic test_ovf;
    int cyc;
    send_one(16'h7FFF, 16'h0001, 1'b0);
    wait_out4(cyc);
    n_tests++;
    if (cyc != 4 || sum !== 16'h8000 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos: got cyc=%0d sum=%h ovf=%b, required 4 8000 1", cyc, sum, ovf);
    end
    send_one(16'h8000, 16'hFFFF, 1'b0);
    wait_out4(cyc);
    n_tests++;
    if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b, required 7fff 1 1", sum, cout, ovf);
    end
    send_one(16'h0001, 16'h0001, 1'b0);
    wait_out4(cyc);
    n_tests++;
    if (sum !== 16'h0002 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_none: got sum=%h ovf=%b, required 0002 0", sum, ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_PIPE_OVF_EN
    test_ovf();
`endif
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got pending4=%0d pending1=%0d, required 0 0",
               q4.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required to finish earlier");
    $fatal(1, "timeout");
  end

endmodule
